// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - AHB3-Lite bus encodings shared by the interconnect.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_B8    = 3'b000;
  localparam logic [2:0] HSIZE_B16   = 3'b001;
  localparam logic [2:0] HSIZE_B32   = 3'b010;
  localparam logic [2:0] HSIZE_B64   = 3'b011;
  localparam logic [2:0] HSIZE_B128  = 3'b100;
  localparam logic [2:0] HSIZE_B256  = 3'b101;
  localparam logic [2:0] HSIZE_B512  = 3'b110;
  localparam logic [2:0] HSIZE_B1024 = 3'b111;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // NONSEQ and SEQ are the only transfer types that carry a data phase.
  function automatic logic is_xfer(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb3lite_interconnect_master_decoder.sv
// rtl/ahb3lite_interconnect_master_decoder.sv - address to slave-port decoder.
// Lowest matching slave index wins when address windows overlap.
module ahb3lite_interconnect_master_decoder #(
  parameter int SLAVES     = 8,
  parameter int HADDR_SIZE = 32,
  localparam int SLAVE_BITS = (SLAVES == 1) ? 1 : $clog2(SLAVES)
) (
  input  logic [HADDR_SIZE-1:0] addr,
  input  logic [HADDR_SIZE-1:0] base [SLAVES],
  input  logic [HADDR_SIZE-1:0] mask [SLAVES],
  output logic [SLAVES-1:0]     hit,
  output logic [SLAVE_BITS-1:0] index,
  output logic                  none
);

  always_comb begin
    hit   = '0;
    index = '0;
    none  = 1'b1;
    for (int s = 0; s < SLAVES; s++) begin
      if (none && ((addr & mask[s]) == base[s])) begin
        hit[s] = 1'b1;
        index  = SLAVE_BITS'(s);
        none   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb3lite_interconnect_master_port.sv
// rtl/ahb3lite_interconnect_master_port.sv - per-master port of the AHB3-Lite switch.
// Decodes, holds ungranted address phases, relays responses and answers unmapped addresses.
module ahb3lite_interconnect_master_port
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MASTERS     = 3,
  parameter int SLAVES      = 8,
  parameter int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS),
  parameter int SLAVE_BITS  = (SLAVES == 1) ? 1 : $clog2(SLAVES)
) (
  input  logic                   HRESETn,
  input  logic                   HCLK,
  input  logic [MASTER_BITS-1:0] mstpriority,
  input  logic                   mstHSEL,
  input  logic [HADDR_SIZE-1:0]  mstHADDR,
  input  logic [HDATA_SIZE-1:0]  mstHWDATA,
  input  logic                   mstHWRITE,
  input  logic [2:0]             mstHSIZE,
  input  logic [2:0]             mstHBURST,
  input  logic [3:0]             mstHPROT,
  input  logic [1:0]             mstHTRANS,
  input  logic                   mstHMASTLOCK,
  input  logic                   mstHREADY,
  output logic [HDATA_SIZE-1:0]  mstHRDATA,
  output logic                   mstHREADYOUT,
  output logic                   mstHRESP,
  input  logic [HADDR_SIZE-1:0]  slvHADDRbase [SLAVES],
  input  logic [HADDR_SIZE-1:0]  slvHADDRmask [SLAVES],
  output logic [MASTER_BITS-1:0] slvpriority,
  output logic [SLAVES-1:0]      slvHSEL,
  output logic [HADDR_SIZE-1:0]  slvHADDR,
  output logic [HDATA_SIZE-1:0]  slvHWDATA,
  output logic                   slvHWRITE,
  output logic [2:0]             slvHSIZE,
  output logic [2:0]             slvHBURST,
  output logic [3:0]             slvHPROT,
  output logic [1:0]             slvHTRANS,
  output logic                   slvHMASTLOCK,
  output logic                   slvHREADYOUT,
  input  logic [SLAVES-1:0]      slvHREADY,
  input  logic [SLAVES-1:0]      slvHRESP,
  input  logic [HDATA_SIZE-1:0]  slvHRDATA [SLAVES],
  input  logic [SLAVES-1:0]      granted,
  output logic [SLAVES-1:0]      can_switch
);

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  localparam logic [SLAVES-1:0] ONE_HOT_BASE = 1;

  state_t                 state;
  logic [SLAVE_BITS-1:0]  tgt;
  logic [HADDR_SIZE-1:0]  hold_haddr;
  logic                   hold_hwrite;
  logic [2:0]             hold_hsize;
  logic [2:0]             hold_hburst;
  logic [3:0]             hold_hprot;
  logic                   hold_hmastlock;

  logic [SLAVES-1:0]      dec_hit;
  logic [SLAVE_BITS-1:0]  dec_index;
  logic                   dec_none;
  logic                   live_sel;
  logic                   req;
  logic                   ready_phase;
  logic                   accept;

  ahb3lite_interconnect_master_decoder #(
    .SLAVES     (SLAVES),
    .HADDR_SIZE (HADDR_SIZE)
  ) u_decoder (
    .addr  (mstHADDR),
    .base  (slvHADDRbase),
    .mask  (slvHADDRmask),
    .hit   (dec_hit),
    .index (dec_index),
    .none  (dec_none)
  );

  // Gating with HRESETn keeps the switch side quiet while reset is held.
  assign live_sel = HRESETn & mstHSEL;
  assign req      = live_sel & is_xfer(mstHTRANS);

  always_comb begin
    ready_phase = 1'b0;
    case (state)
      IDLE, ERR2: ready_phase = 1'b1;
      DATA:       ready_phase = slvHREADY[tgt];
      default:    ready_phase = 1'b0;
    endcase
  end

  assign accept = req & mstHREADY & ready_phase;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state          <= IDLE;
      tgt            <= '0;
      hold_haddr     <= '0;
      hold_hwrite    <= 1'b0;
      hold_hsize     <= '0;
      hold_hburst    <= '0;
      hold_hprot     <= '0;
      hold_hmastlock <= 1'b0;
    end else begin
      if (accept) begin
        hold_haddr     <= mstHADDR;
        hold_hwrite    <= mstHWRITE;
        hold_hsize     <= mstHSIZE;
        hold_hburst    <= mstHBURST;
        hold_hprot     <= mstHPROT;
        hold_hmastlock <= mstHMASTLOCK;
      end
      case (state)
        ERR1: state <= ERR2;
        WAIT: if (granted[tgt] && slvHREADY[tgt]) state <= DATA;
        default: begin
          if (ready_phase) begin
            if (accept) begin
              tgt <= dec_index;
              if (dec_none)              state <= ERR1;
              else if (granted[dec_index]) state <= DATA;
              else                       state <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    mstHREADYOUT = 1'b1;
    mstHRESP     = HRESP_OKAY;
    mstHRDATA    = '0;
    case (state)
      WAIT: mstHREADYOUT = 1'b0;
      DATA: begin
        mstHREADYOUT = slvHREADY[tgt];
        mstHRESP     = slvHRESP[tgt];
        mstHRDATA    = slvHRDATA[tgt];
      end
      ERR1: begin
        mstHREADYOUT = 1'b0;
        mstHRESP     = HRESP_ERROR;
      end
      ERR2: mstHRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // A held address phase is always reissued as NONSEQ, since the burst context was broken.
  always_comb begin
    if (state == WAIT) begin
      slvHSEL      = ONE_HOT_BASE << tgt;
      slvHADDR     = hold_haddr;
      slvHWRITE    = hold_hwrite;
      slvHSIZE     = hold_hsize;
      slvHBURST    = hold_hburst;
      slvHPROT     = hold_hprot;
      slvHTRANS    = HTRANS_NONSEQ;
      slvHMASTLOCK = hold_hmastlock;
    end else begin
      slvHSEL      = (req && !dec_none) ? dec_hit : '0;
      slvHADDR     = mstHADDR;
      slvHWRITE    = mstHWRITE;
      slvHSIZE     = mstHSIZE;
      slvHBURST    = mstHBURST;
      slvHPROT     = mstHPROT;
      slvHTRANS    = live_sel ? mstHTRANS : HTRANS_IDLE;
      slvHMASTLOCK = live_sel & mstHMASTLOCK;
    end
  end

  always_comb begin
    can_switch = '0;
    for (int s = 0; s < SLAVES; s++) begin
      can_switch[s] = !slvHMASTLOCK &&
                      !(slvHTRANS == HTRANS_SEQ || slvHTRANS == HTRANS_BUSY) &&
                      !(state == WAIT && tgt == SLAVE_BITS'(s));
    end
  end

  assign slvHWDATA    = mstHWDATA;
  assign slvHREADYOUT = mstHREADYOUT;
  assign slvpriority  = mstpriority;

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// tb/tb_ahb3lite_interconnect_master_port.sv - directed bench for the switch master port.
module tb_ahb3lite_interconnect_master_port;
  import ahb3lite_pkg::*;

  localparam int HA = 32;
  localparam int HD = 32;
  localparam int S  = 2;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [1:0]    mstpriority;
  logic          mstHSEL;
  logic [HA-1:0] mstHADDR;
  logic [HD-1:0] mstHWDATA;
  logic          mstHWRITE;
  logic [2:0]    mstHSIZE;
  logic [2:0]    mstHBURST;
  logic [3:0]    mstHPROT;
  logic [1:0]    mstHTRANS;
  logic          mstHMASTLOCK;
  logic [HD-1:0] mstHRDATA;
  logic          mstHREADYOUT;
  logic          mstHRESP;
  logic [HA-1:0] slvHADDRbase [S];
  logic [HA-1:0] slvHADDRmask [S];
  logic [1:0]    slvpriority;
  logic [S-1:0]  slvHSEL;
  logic [HA-1:0] slvHADDR;
  logic [HD-1:0] slvHWDATA;
  logic          slvHWRITE;
  logic [2:0]    slvHSIZE;
  logic [2:0]    slvHBURST;
  logic [3:0]    slvHPROT;
  logic [1:0]    slvHTRANS;
  logic          slvHMASTLOCK;
  logic          slvHREADYOUT;
  logic [S-1:0]  slvHREADY;
  logic [S-1:0]  slvHRESP;
  logic [HD-1:0] slvHRDATA [S];
  logic [S-1:0]  granted;
  logic [S-1:0]  can_switch;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_interconnect_master_port #(
    .HADDR_SIZE (HA),
    .HDATA_SIZE (HD),
    .MASTERS    (3),
    .SLAVES     (S)
  ) dut (
    .HRESETn      (HRESETn),
    .HCLK         (HCLK),
    .mstpriority  (mstpriority),
    .mstHSEL      (mstHSEL),
    .mstHADDR     (mstHADDR),
    .mstHWDATA    (mstHWDATA),
    .mstHWRITE    (mstHWRITE),
    .mstHSIZE     (mstHSIZE),
    .mstHBURST    (mstHBURST),
    .mstHPROT     (mstHPROT),
    .mstHTRANS    (mstHTRANS),
    .mstHMASTLOCK (mstHMASTLOCK),
    .mstHREADY    (mstHREADYOUT),
    .mstHRDATA    (mstHRDATA),
    .mstHREADYOUT (mstHREADYOUT),
    .mstHRESP     (mstHRESP),
    .slvHADDRbase (slvHADDRbase),
    .slvHADDRmask (slvHADDRmask),
    .slvpriority  (slvpriority),
    .slvHSEL      (slvHSEL),
    .slvHADDR     (slvHADDR),
    .slvHWDATA    (slvHWDATA),
    .slvHWRITE    (slvHWRITE),
    .slvHSIZE     (slvHSIZE),
    .slvHBURST    (slvHBURST),
    .slvHPROT     (slvHPROT),
    .slvHTRANS    (slvHTRANS),
    .slvHMASTLOCK (slvHMASTLOCK),
    .slvHREADYOUT (slvHREADYOUT),
    .slvHREADY    (slvHREADY),
    .slvHRESP     (slvHRESP),
    .slvHRDATA    (slvHRDATA),
    .granted      (granted),
    .can_switch   (can_switch)
  );

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle;
    @(negedge HCLK);
  endtask

  task automatic bus_idle;
    mstHSEL      = 1'b0;
    mstHTRANS    = HTRANS_IDLE;
    mstHADDR     = '0;
    mstHWRITE    = 1'b0;
    mstHSIZE     = HSIZE_B32;
    mstHBURST    = HBURST_SINGLE;
    mstHPROT     = 4'b0011;
    mstHMASTLOCK = 1'b0;
  endtask

  task automatic drive_xfer(input logic [31:0] a, input logic [1:0] tr, input logic wr,
                            input logic [2:0] bu, input logic lk);
    mstHSEL      = 1'b1;
    mstHADDR     = a;
    mstHTRANS    = tr;
    mstHWRITE    = wr;
    mstHBURST    = bu;
    mstHMASTLOCK = lk;
    mstHSIZE     = HSIZE_B32;
    mstHPROT     = 4'b0011;
  endtask

  task automatic test_reset;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout got %b want 1", mstHREADYOUT); end
    n_cmp++; if (mstHRESP !== 1'b0) begin n_bad++; $display("FAIL reset_hresp got %b want 0", mstHRESP); end
    n_cmp++; if (mstHRDATA !== 32'h0) begin n_bad++; $display("FAIL reset_hrdata got %h want 0", mstHRDATA); end
    n_cmp++; if (slvHSEL !== 2'b00) begin n_bad++; $display("FAIL reset_hsel got %b want 00", slvHSEL); end
    n_cmp++; if (slvHTRANS !== HTRANS_IDLE) begin n_bad++; $display("FAIL reset_htrans got %b want 00", slvHTRANS); end
    n_cmp++; if (can_switch !== 2'b11) begin n_bad++; $display("FAIL reset_can_switch got %b want 11", can_switch); end
    n_cmp++; if (slvpriority !== 2'd2) begin n_bad++; $display("FAIL priority_fwd got %0d want 2", slvpriority); end
    tick;
    HRESETn = 1'b1;
  endtask

  task automatic test_granted_read;
    granted      = 2'b11;
    slvHRDATA[1] = 32'hCAFE_F00D;
    drive_xfer(32'h1000_0040, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0);
    settle;
    n_cmp++; if (slvHSEL !== 2'b10) begin n_bad++; $display("FAIL read_hsel got %b want 10", slvHSEL); end
    n_cmp++; if (slvHADDR !== 32'h1000_0040) begin n_bad++; $display("FAIL read_haddr got %h want 10000040", slvHADDR); end
    n_cmp++; if (mstHREADYOUT !== 1'b1) begin n_bad++; $display("FAIL read_addr_ready got %b want 1", mstHREADYOUT); end
    tick;
    bus_idle;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b1) begin n_bad++; $display("FAIL read_data_ready got %b want 1", mstHREADYOUT); end
    n_cmp++; if (mstHRDATA !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL read_hrdata got %h want cafef00d", mstHRDATA); end
    n_cmp++; if (mstHRESP !== 1'b0) begin n_bad++; $display("FAIL read_hresp got %b want 0", mstHRESP); end
    tick;
  endtask

  task automatic test_wait_write;
    granted = 2'b00;
    drive_xfer(32'h0000_0010, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 1'b0);
    settle;
    n_cmp++; if (slvHSEL !== 2'b01) begin n_bad++; $display("FAIL wait_req_hsel got %b want 01", slvHSEL); end
    tick;
    bus_idle;
    mstHADDR  = 32'h0FFF_FFF0;
    mstHWDATA = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      granted = (i == 3) ? 2'b01 : 2'b00;
      settle;
      n_cmp++; if (mstHREADYOUT !== 1'b0) begin n_bad++; $display("FAIL wait_ready[%0d] got %b want 0", i, mstHREADYOUT); end
      n_cmp++; if (slvHADDR !== 32'h0000_0010) begin n_bad++; $display("FAIL wait_haddr[%0d] got %h want 00000010", i, slvHADDR); end
      n_cmp++; if (slvHTRANS !== HTRANS_NONSEQ) begin n_bad++; $display("FAIL wait_htrans[%0d] got %b want 10", i, slvHTRANS); end
      n_cmp++; if (slvHSEL !== 2'b01 || slvHWRITE !== 1'b1) begin n_bad++; $display("FAIL wait_hsel[%0d] got %b/%b want 01/1", i, slvHSEL, slvHWRITE); end
      n_cmp++; if (can_switch !== 2'b10) begin n_bad++; $display("FAIL wait_can_switch[%0d] got %b want 10", i, can_switch); end
      tick;
    end
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b1) begin n_bad++; $display("FAIL wait_done_ready got %b want 1", mstHREADYOUT); end
    n_cmp++; if (slvHWDATA !== 32'h1234_5678) begin n_bad++; $display("FAIL wait_hwdata got %h want 12345678", slvHWDATA); end
    tick;
    granted = 2'b11;
  endtask

  task automatic test_unmapped;
    drive_xfer(32'h2000_0000, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0);
    settle;
    n_cmp++; if (slvHSEL !== 2'b00) begin n_bad++; $display("FAIL unmap_addr_hsel got %b want 00", slvHSEL); end
    tick;
    bus_idle;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b0 || mstHRESP !== 1'b1) begin n_bad++; $display("FAIL unmap_err1 got rdy=%b resp=%b want 0/1", mstHREADYOUT, mstHRESP); end
    n_cmp++; if (slvHSEL !== 2'b00) begin n_bad++; $display("FAIL unmap_err1_hsel got %b want 00", slvHSEL); end
    tick;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b1 || mstHRESP !== 1'b1) begin n_bad++; $display("FAIL unmap_err2 got rdy=%b resp=%b want 1/1", mstHREADYOUT, mstHRESP); end
    tick;
    settle;
    n_cmp++; if (mstHRESP !== 1'b0) begin n_bad++; $display("FAIL unmap_after_hresp got %b want 0", mstHRESP); end
    tick;
  endtask

  task automatic test_burst(input logic lk);
    logic [1:0] exp;
    for (int b = 0; b < 4; b++) begin
      drive_xfer(32'h1000_0000 + 32'(4 * b), (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HBURST_INCR4, lk);
      exp = lk ? 2'b00 : ((b == 0) ? 2'b11 : 2'b00);
      settle;
      n_cmp++; if (can_switch !== exp) begin n_bad++; $display("FAIL burst_lock%0b_beat%0d can_switch got %b want %b", lk, b, can_switch, exp); end
      n_cmp++; if (slvHSEL !== 2'b10) begin n_bad++; $display("FAIL burst_lock%0b_beat%0d hsel got %b want 10", lk, b, slvHSEL); end
      tick;
    end
    bus_idle;
    settle;
    n_cmp++; if (can_switch !== 2'b11) begin n_bad++; $display("FAIL burst_lock%0b_end can_switch got %b want 11", lk, can_switch); end
    tick;
  endtask

  task automatic test_slave_error;
    logic rdy_t [4];
    logic rsp_t [4];
    rdy_t = '{1'b0, 1'b0, 1'b0, 1'b1};
    rsp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
    drive_xfer(32'h1000_0000, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0);
    tick;
    bus_idle;
    for (int i = 0; i < 4; i++) begin
      slvHREADY = {rdy_t[i], 1'b1};
      slvHRESP  = {rsp_t[i], 1'b0};
      settle;
      n_cmp++; if (mstHREADYOUT !== rdy_t[i] || mstHRESP !== rsp_t[i]) begin n_bad++; $display("FAIL slverr[%0d] got rdy=%b resp=%b want %b/%b", i, mstHREADYOUT, mstHRESP, rdy_t[i], rsp_t[i]); end
      tick;
    end
    slvHREADY = 2'b11;
    slvHRESP  = 2'b00;
  endtask

  task automatic test_back_to_back;
    granted      = 2'b10;
    slvHRDATA[0] = 32'h0000_1111;
    slvHRDATA[1] = 32'h5555_AAAA;
    drive_xfer(32'h1000_0100, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0);
    tick;
    drive_xfer(32'h0000_0200, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0);
    settle;
    n_cmp++; if (mstHRDATA !== 32'h5555_AAAA || mstHREADYOUT !== 1'b1) begin n_bad++; $display("FAIL b2b_first got %h/%b want 5555aaaa/1", mstHRDATA, mstHREADYOUT); end
    n_cmp++; if (slvHSEL !== 2'b01) begin n_bad++; $display("FAIL b2b_next_hsel got %b want 01", slvHSEL); end
    tick;
    bus_idle;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b0 || slvHADDR !== 32'h0000_0200) begin n_bad++; $display("FAIL b2b_hold got %b/%h want 0/00000200", mstHREADYOUT, slvHADDR); end
    tick;
    granted = 2'b11;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b0) begin n_bad++; $display("FAIL b2b_grant_cycle got %b want 0", mstHREADYOUT); end
    tick;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b1 || mstHRDATA !== 32'h0000_1111) begin n_bad++; $display("FAIL b2b_second got %b/%h want 1/00001111", mstHREADYOUT, mstHRDATA); end
    tick;
  endtask

  task automatic test_reset_in_wait;
    granted = 2'b00;
    drive_xfer(32'h0000_0030, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 1'b0);
    tick;
    bus_idle;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b0) begin n_bad++; $display("FAIL rstwait_pre got %b want 0", mstHREADYOUT); end
    #2;
    HRESETn = 1'b0;
    #1;
    n_cmp++; if (mstHREADYOUT !== 1'b1) begin n_bad++; $display("FAIL rstwait_ready got %b want 1", mstHREADYOUT); end
    n_cmp++; if (slvHSEL !== 2'b00) begin n_bad++; $display("FAIL rstwait_hsel got %b want 00", slvHSEL); end
    n_cmp++; if (can_switch !== 2'b11) begin n_bad++; $display("FAIL rstwait_can_switch got %b want 11", can_switch); end
    tick;
    HRESETn   = 1'b1;
    granted   = 2'b11;
    slvHREADY = 2'b00;
    settle;
    n_cmp++; if (mstHREADYOUT !== 1'b1 || mstHRESP !== 1'b0) begin n_bad++; $display("FAIL rstwait_idle got %b/%b want 1/0", mstHREADYOUT, mstHRESP); end
    tick;
    slvHREADY = 2'b11;
  endtask

  initial begin
    HRESETn         = 1'b0;
    mstpriority     = 2'd2;
    mstHWDATA       = '0;
    bus_idle;
    slvHADDRbase[0] = 32'h0000_0000;
    slvHADDRmask[0] = 32'hF000_0000;
    slvHADDRbase[1] = 32'h1000_0000;
    slvHADDRmask[1] = 32'hF000_0000;
    slvHRDATA[0]    = '0;
    slvHRDATA[1]    = '0;
    slvHREADY       = 2'b11;
    slvHRESP        = 2'b00;
    granted         = 2'b11;

    test_reset;
    test_granted_read;
    test_wait_write;
    test_unmapped;
    test_burst(1'b1);
    test_burst(1'b0);
    test_slave_error;
    test_back_to_back;
    test_reset_in_wait;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
